// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the CPU-to-timer bridge.
// Both the FSM and the address decoder import these definitions.
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  localparam logic [31:0] DefT0Base   = 32'h0000_7F00;
  localparam logic [31:0] DefT1Base   = 32'h0000_7F10;
  localparam int unsigned WindowWords = 3;

  // Unsigned wrap-around makes addresses below the base land far outside the window.
  function automatic logic in_window(input logic [29:0] word, input logic [29:0] base_word);
    logic [29:0] off;
    off = word - base_word;
    return off < 30'(WindowWords);
  endfunction

endpackage

// File: rtl/bridge_decode.sv
// Combinational word-address decoder for the two timer windows.
// Timer 0 takes priority if the windows ever overlap.
module bridge_decode
  import sys_bridge_pkg::*;
#(
  parameter logic [31:0] T0Base = DefT0Base,
  parameter logic [31:0] T1Base = DefT1Base
) (
  input  logic [29:0] word_addr_i,
  output logic        t0_hit_o,
  output logic        t1_hit_o,
  output logic        miss_o
);

  always_comb begin
    t0_hit_o = in_window(word_addr_i, T0Base[31:2]);
    t1_hit_o = !t0_hit_o && in_window(word_addr_i, T1Base[31:2]);
    miss_o   = !(t0_hit_o || t1_hit_o);
  end

endmodule

// File: rtl/sys_bridge.sv
// Single-outstanding CPU bridge to two memory-mapped timers.
// Each access walks IDLE -> ACCESS -> RESP; interrupts are registered independently.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter logic [31:0] T0_BASE = DefT0Base,
  parameter logic [31:0] T1_BASE = DefT1Base
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [29:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic        t0_we,
  output logic        t1_we,
  input  logic [31:0] t0_dout,
  input  logic [31:0] t1_dout,
  input  logic        t0_irq,
  input  logic        t1_irq,
  output logic [5:0]  hwint
);

  state_e      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [5:0]  hwint_q;
  logic        ready_en_q;

  logic t0_hit, t1_hit, miss;

  // Byte-lane bits carry no meaning for word-wide timer registers.
  logic unused_byte_sel;
  assign unused_byte_sel = ^req_addr[1:0];

  bridge_decode #(
    .T0Base(T0_BASE),
    .T1Base(T1_BASE)
  ) u_decode (
    .word_addr_i(addr_q),
    .t0_hit_o   (t0_hit),
    .t1_hit_o   (t1_hit),
    .miss_o     (miss)
  );

  // Keeps req_ready low through reset and only raises it on the first edge after release.
  assign req_ready = ready_en_q && (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dev_addr  = addr_q;
  assign dev_wdata = wdata_q;
  assign hwint     = hwint_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    t0_we   = 1'b0;
    t1_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr[31:2];
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = StAccess;
        end
      end
      StAccess: begin
        t0_we   = we_q && t0_hit;
        t1_we   = we_q && t1_hit;
        err_d   = miss;
        if (we_q || miss) begin
          rdata_d = 32'd0;
        end else if (t0_hit) begin
          rdata_d = t0_dout;
        end else begin
          rdata_d = t1_dout;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      hwint_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      hwint_q    <= {4'b0000, t1_irq, t0_irq};
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/sys_bridge.md
SYS_BRIDGE -- requirements
Module: sys_bridge

Interface
REQ-001 SHALL have parameter T0_BASE, default 32'h0000_7F00, timer 0 base (3 words).
REQ-002 SHALL have parameter T1_BASE, default 32'h0000_7F10, timer 1 base (3 words).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  CPU access request.
REQ-006 SHALL have port req_ready  output  1  bridge can accept a request.
REQ-007 SHALL have port req_addr  input  32  CPU byte address, bits [1:0] ignored.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  CPU accepts response.
REQ-012 SHALL have port rsp_rdata  output  32  load data, 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  address outside both timer windows.
REQ-014 SHALL have port dev_addr  output  30  word address [31:2] to devices.
REQ-015 SHALL have port dev_wdata  output  32  write data to devices.
REQ-016 SHALL have port t0_we / t1_we  output  1 each  per-timer write strobe.
REQ-017 SHALL have port t0_dout / t1_dout  input  32 each  timer read data (combinational in device).
REQ-018 SHALL have port t0_irq / t1_irq  input  1 each  timer interrupt lines.
REQ-019 SHALL have port hwint  output  6  registered interrupt vector to CP0.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-021 SHALL drive req_ready=1 only in IDLE; handshake = req_valid & req_ready.
REQ-022 SHALL capture addr, we, wdata into registers on handshake and enter ACCESS.
REQ-023 SHALL decode a hit when captured addr[31:2] - base[31:2] is in 0..2; offset 3 counts as a miss.
REQ-024 SHALL in ACCESS assert exactly one of t0_we/t1_we for exactly one cycle on a store hit, none otherwise.
REQ-025 SHALL in ACCESS latch the selected t*_dout into rsp_rdata on a load hit, 0 otherwise, then enter RESP.
REQ-026 SHALL set rsp_err=1 for a miss; a missed store SHALL produce no device strobe.
REQ-027 SHALL in RESP hold rsp_valid=1 with rsp_rdata/rsp_err stable until rsp_ready=1, then return to IDLE.
REQ-028 SHALL give load latency of 2 cycles from handshake to rsp_valid; the next request is accepted no earlier than the cycle after the response handshake.
REQ-029 SHALL drive dev_addr/dev_wdata from captured registers at all times, stable through ACCESS.
REQ-030 SHALL register hwint = {4'b0, t1_irq, t0_irq} every cycle, independent of the FSM.
REQ-031 SHALL make t0 decode win over t1 if the windows overlap under misconfiguration.

Reset
REQ-032 SHALL, on reset low, immediately force state=IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, t0_we=t1_we=0, hwint=0, captured regs=0.
REQ-033 SHALL make reset during ACCESS abort the access: no strobe after assertion, no response after release.
REQ-034 SHALL hold req_ready=0 while reset is low, then 1 from the first edge after release.

Structure
REQ-035 SHALL place the FSM state encodings, the default base addresses, and the window size (3) in the shared package.
REQ-036 SHALL use one sub-module, bridge_decode: a combinational address-to-{t0_hit, t1_hit, miss} decoder.

Verification
REQ-037 SHALL test a store to 0x7F04 with data 0x0000_000A -> t0_we high for one cycle, dev_addr=0x1FC1, rsp_err=0.
REQ-038 SHALL test a load from 0x7F18 with t1_dout=0x1234_5678 -> rsp_valid two cycles after handshake, rsp_rdata=0x1234_5678.
REQ-039 SHALL test a load from 0x7F0C -> rsp_err=1, rsp_rdata=0, no strobe.
REQ-040 SHALL test rsp_ready held low for 5 cycles -> rsp_valid and data held stable, req_ready=0 throughout.
REQ-041 SHALL test reset asserted mid-ACCESS for a store to 0x7F10 -> no t1_we pulse, all outputs 0, IDLE on release.
REQ-042 SHALL test t0_irq pulsed for one cycle -> hwint=6'b000001 exactly one cycle later for one cycle.
